// File: rtl/hd_video_pkg.sv
// Shared 720p50 raster constants, counter widths and genlock FSM encoding.
package hd_video_pkg;

    localparam int unsigned HCNT_W = 12;
    localparam int unsigned VCNT_W = 11;

    localparam int unsigned HD_H_ACTIVE = 1280;
    localparam int unsigned HD_H_FP     = 440;
    localparam int unsigned HD_H_SYNC   = 40;
    localparam int unsigned HD_H_BP     = 220;
    localparam int unsigned HD_V_ACTIVE = 720;
    localparam int unsigned HD_V_FP     = 5;
    localparam int unsigned HD_V_SYNC   = 5;
    localparam int unsigned HD_V_BP     = 20;

    localparam logic [0:0] StSearch = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    // Shortest distance between two line numbers on a raster of 'total' lines.
    function automatic logic [11:0] line_dist(input logic [11:0] a, input logic [11:0] b,
                                              input logic [11:0] total);
        logic [11:0] d;
        d = (a >= b) ? a - b : b - a;
        return (d > total - d) ? total - d : d;
    endfunction

endpackage

// File: rtl/hd_timing_cnt.sv
// Pixel divider plus horizontal/vertical raster counters with a vertical load port for realign.
module hd_timing_cnt
    import hd_video_pkg::*;
#(
    parameter int unsigned PIX_DIV = 2,
    parameter int unsigned H_TOTAL = 1980,
    parameter int unsigned V_TOTAL = 750
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [VCNT_W-1:0] load_val,
    output logic              pix_next,
    output logic              pix_en,
    output logic              hd_clk,
    output logic [HCNT_W-1:0] h,
    output logic [VCNT_W-1:0] v,
    output logic              h_wrap
);

    localparam int unsigned       DIV_W    = $clog2(PIX_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(PIX_DIV / 2);
    localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0]  div_q;
    logic              pix_en_q;
    logic              hd_clk_q;
    logic [HCNT_W-1:0] h_q;
    logic [VCNT_W-1:0] v_q;

    assign pix_next = (div_q == '0);
    assign h_wrap   = pix_en_q && (h_q == H_LAST);
    assign pix_en   = pix_en_q;
    assign hd_clk   = hd_clk_q;
    assign h        = h_q;
    assign v        = v_q;

    // Divider drives the pixel strobe/clock; counters advance on the strobe, load wins at wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            hd_clk_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
        end else begin
            div_q    <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            pix_en_q <= (div_q == '0);
            hd_clk_q <= (div_q >= DIV_HALF);
            if (pix_en_q) begin
                if (h_wrap) begin
                    h_q <= '0;
                    if (load_en) begin
                        v_q <= load_val;
                    end else begin
                        v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
                    end
                end else begin
                    h_q <= h_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hd_timing_gen.sv
// 720p50 raster timing generator with optional genlock to the PAL frame-end pulse.
// Define HD_GENLOCK_EN to build the genlock FSM and vertical realign; otherwise free-running.
module hd_timing_gen
    import hd_video_pkg::*;
#(
    parameter int unsigned PIX_DIV   = 2,
    parameter int unsigned H_ACTIVE  = HD_H_ACTIVE,
    parameter int unsigned H_FP      = HD_H_FP,
    parameter int unsigned H_SYNC    = HD_H_SYNC,
    parameter int unsigned H_BP      = HD_H_BP,
    parameter int unsigned V_ACTIVE  = HD_V_ACTIVE,
    parameter int unsigned V_FP      = HD_V_FP,
    parameter int unsigned V_SYNC    = HD_V_SYNC,
    parameter int unsigned V_BP      = HD_V_BP,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter int unsigned LOCK_LINE = 725,
    parameter int unsigned LOCK_TOL  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_frame_end,
    output logic              o_hd_clk,
    output logic              o_hd_pix_en,
    output logic              o_hd_hsync,
    output logic              o_hd_vsync,
    output logic              o_hd_de,
    output logic [HCNT_W-1:0] o_hd_x,
    output logic [VCNT_W-1:0] o_hd_y,
    output logic              o_frame_start,
    output logic              o_locked
);

    localparam int unsigned       H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned       V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [HCNT_W-1:0] H_ACT    = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_START = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] HS_END   = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCNT_W-1:0] V_ACT    = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] VS_START = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VS_END   = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic              pix_next;
    logic              h_wrap;
    logic [HCNT_W-1:0] h;
    logic [VCNT_W-1:0] v;
    logic              load_en;
    logic [VCNT_W-1:0] load_val;

    logic              hsync_q, vsync_q, de_q, frame_start_q;
    logic [HCNT_W-1:0] x_q;
    logic [VCNT_W-1:0] y_q;

    hd_timing_cnt #(
        .PIX_DIV (PIX_DIV),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .load_val (load_val),
        .pix_next (pix_next),
        .pix_en   (o_hd_pix_en),
        .hd_clk   (o_hd_clk),
        .h        (h),
        .v        (v),
        .h_wrap   (h_wrap)
    );

    // Registered decode; aligns sync/DE/x/y with the pixel strobe that starts each pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
        end else begin
            hsync_q       <= ((h >= HS_START) && (h < HS_END)) ? HS_POL : ~HS_POL;
            vsync_q       <= ((v >= VS_START) && (v < VS_END)) ? VS_POL : ~VS_POL;
            de_q          <= (h < H_ACT) && (v < V_ACT);
            frame_start_q <= pix_next && (h == '0) && (v == '0);
            x_q           <= h;
            y_q           <= v;
        end
    end

    assign o_hd_hsync    = hsync_q;
    assign o_hd_vsync    = vsync_q;
    assign o_hd_de       = de_q;
    assign o_frame_start = frame_start_q;
    assign o_hd_x        = x_q;
    assign o_hd_y        = y_q;
    assign load_val      = VCNT_W'(LOCK_LINE);

`ifdef HD_GENLOCK_EN
    logic [0:0]  state_q, state_d;
    logic [1:0]  miss_q, miss_d;
    logic        pending_q, pending_d;
    logic        set_pending;
    logic        in_tol;
    logic [11:0] dist;

    assign dist   = line_dist(12'(v), 12'(LOCK_LINE), 12'(V_TOTAL));
    assign in_tol = (dist <= 12'(LOCK_TOL));

    // Genlock decision on each PAL frame end; two consecutive misses drop lock.
    always_comb begin
        state_d     = state_q;
        miss_d      = miss_q;
        set_pending = 1'b0;
        if (i_frame_end) begin
            case (state_q)
                StSearch: begin
                    if (in_tol) begin
                        state_d = StLocked;
                        miss_d  = '0;
                    end else begin
                        set_pending = 1'b1;
                    end
                end
                StLocked: begin
                    if (in_tol) begin
                        miss_d = '0;
                    end else if (miss_q == 2'd1) begin
                        state_d     = StSearch;
                        miss_d      = '0;
                        set_pending = 1'b1;
                    end else begin
                        miss_d = miss_q + 2'd1;
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    // A pulse landing on the wrap cycle realigns immediately; the flag never stacks.
    assign load_en   = pending_q | set_pending;
    assign pending_d = h_wrap ? 1'b0 : (pending_q | set_pending);

    // Genlock state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StSearch;
            miss_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            miss_q    <= miss_d;
            pending_q <= pending_d;
        end
    end

    assign o_locked = (state_q == StLocked);
`else
    logic unused_sigs;
    assign unused_sigs = ^{i_frame_end, h_wrap, 12'(LOCK_TOL)};
    assign load_en     = 1'b0;
    assign o_locked    = 1'b0;
`endif

endmodule

// File: tb/tb_hd_timing_gen.sv
// Directed bench for hd_timing_gen on a shrunken 24x12 raster.
module tb_hd_timing_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_frame_end = 1'b0;
    logic        o_hd_clk, o_hd_pix_en, o_hd_hsync, o_hd_vsync, o_hd_de;
    logic [11:0] o_hd_x;
    logic [10:0] o_hd_y;
    logic        o_frame_start, o_locked;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hd_timing_gen #(
        .PIX_DIV   (2),
        .H_ACTIVE  (16),
        .H_FP      (2),
        .H_SYNC    (2),
        .H_BP      (4),
        .V_ACTIVE  (8),
        .V_FP      (1),
        .V_SYNC    (1),
        .V_BP      (2),
        .HS_POL    (1'b1),
        .VS_POL    (1'b1),
        .LOCK_LINE (9),
        .LOCK_TOL  (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_frame_end   (i_frame_end),
        .o_hd_clk      (o_hd_clk),
        .o_hd_pix_en   (o_hd_pix_en),
        .o_hd_hsync    (o_hd_hsync),
        .o_hd_vsync    (o_hd_vsync),
        .o_hd_de       (o_hd_de),
        .o_hd_x        (o_hd_x),
        .o_hd_y        (o_hd_y),
        .o_frame_start (o_frame_start),
        .o_locked      (o_locked)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the pixel-strobe cycle showing (x,y).
    task automatic wait_pix(input int x, input int y, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (o_hd_pix_en && int'(o_hd_x) == x && int'(o_hd_y) == y) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    // Advance to the next line start and report its line number.
    task automatic wait_line(output int y, input string tag);
        bit found = 1'b0;
        y = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_hd_pix_en && o_hd_x == 12'd0) begin
                found = 1'b1;
                y = int'(o_hd_y);
                break;
            end
        end
        if (!found) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_frame_start(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (o_frame_start) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    // Starting on a frame_start cycle, measure up to the next frame_start.
    task automatic measure_frame(output int clks, output int de_px, output int vs_px);
        clks  = 0;
        de_px = (o_hd_pix_en && o_hd_de) ? 1 : 0;
        vs_px = (o_hd_pix_en && o_hd_vsync) ? 1 : 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            clks++;
            if (o_frame_start) break;
            if (o_hd_pix_en && o_hd_de) de_px++;
            if (o_hd_pix_en && o_hd_vsync) vs_px++;
        end
    endtask

    task automatic pulse_frame_end();
        i_frame_end = 1'b1;
        @(negedge clk);
        i_frame_end = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int clks, de_px, vs_px, y;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_hd_clk", int'(o_hd_clk), 0);
        check_eq("rst_pix_en", int'(o_hd_pix_en), 0);
        check_eq("rst_de", int'(o_hd_de), 0);
        check_eq("rst_frame_start", int'(o_frame_start), 0);
        check_eq("rst_locked", int'(o_locked), 0);
        check_eq("rst_hsync", int'(o_hd_hsync), 0);
        check_eq("rst_vsync", int'(o_hd_vsync), 0);
        check_eq("rst_x", int'(o_hd_x), 0);
        check_eq("rst_y", int'(o_hd_y), 0);

        // Test 1: first pixel one clock after release, hsync at 18..19
        reset = 1'b0;
        @(negedge clk);
        check_eq("t1_pix_en_first", int'(o_hd_pix_en), 1);
        check_eq("t1_frame_start_first", int'(o_frame_start), 1);
        check_eq("t1_hd_clk_low", int'(o_hd_clk), 0);
        check_eq("t1_de_first", int'(o_hd_de), 1);
        @(negedge clk);
        check_eq("t1_pix_en_second", int'(o_hd_pix_en), 0);
        check_eq("t1_frame_start_pulse", int'(o_frame_start), 0);
        check_eq("t1_hd_clk_high", int'(o_hd_clk), 1);
        wait_pix(15, 0, "t1_x15");
        check_eq("t1_de_x15", int'(o_hd_de), 1);
        wait_pix(16, 0, "t1_x16");
        check_eq("t1_de_x16", int'(o_hd_de), 0);
        wait_pix(17, 0, "t1_x17");
        check_eq("t1_hs_x17", int'(o_hd_hsync), 0);
        wait_pix(18, 0, "t1_x18");
        check_eq("t1_hs_x18", int'(o_hd_hsync), 1);
        wait_pix(19, 0, "t1_x19");
        check_eq("t1_hs_x19", int'(o_hd_hsync), 1);
        check_eq("t1_vs_line0", int'(o_hd_vsync), 0);
        wait_pix(20, 0, "t1_x20");
        check_eq("t1_hs_x20", int'(o_hd_hsync), 0);

        // Test 2: three free-running frames
        wait_frame_start("t2_fs");
        for (int f = 0; f < 3; f++) begin
            measure_frame(clks, de_px, vs_px);
            check_eq($sformatf("t2_period_f%0d", f), clks, 576);
            check_eq($sformatf("t2_de_px_f%0d", f), de_px, 128);
            check_eq($sformatf("t2_vs_px_f%0d", f), vs_px, 24);
        end

`ifdef HD_GENLOCK_EN
        // Test 3: out-of-tolerance pulse realigns, in-tolerance pulse locks
        wait_pix(5, 3, "t3_v3");
        pulse_frame_end();
        check_eq("t3_unlocked", int'(o_locked), 0);
        wait_line(y, "t3_line");
        check_eq("t3_realign_y", y, 9);
        wait_pix(5, 9, "t3_v9");
        pulse_frame_end();
        check_eq("t3_locked", int'(o_locked), 1);
        wait_line(y, "t3_line2");
        check_eq("t3_no_realign_y", y, 10);

        // Test 4: one miss keeps lock, second consecutive miss drops it
        wait_pix(5, 5, "t4_v5");
        pulse_frame_end();
        check_eq("t4_still_locked", int'(o_locked), 1);
        wait_line(y, "t4_line");
        check_eq("t4_no_realign_y", y, 6);
        wait_pix(5, 6, "t4_v6");
        pulse_frame_end();
        check_eq("t4_lock_lost", int'(o_locked), 0);
        wait_line(y, "t4_line2");
        check_eq("t4_realign_y", y, 9);

        // Test 5a: pulse on the wrap cycle realigns at that wrap
        wait_pix(23, 4, "t5_wrap");
        pulse_frame_end();
        wait_line(y, "t5_line");
        check_eq("t5_same_wrap_y", y, 9);
        wait_line(y, "t5_line2");
        check_eq("t5_pending_clear_y", y, 10);
`else
        // Test 6: frame-end pulses have no effect without genlock
        wait_pix(5, 3, "t6_v3");
        pulse_frame_end();
        check_eq("t6_locked", int'(o_locked), 0);
        wait_line(y, "t6_line");
        check_eq("t6_no_realign_y", y, 4);
        wait_frame_start("t6_fs");
        measure_frame(clks, de_px, vs_px);
        check_eq("t6_period", clks, 576);
        check_eq("t6_de_px", de_px, 128);
`endif

        // Test 5b: reset in the middle of a sync pixel
        wait_pix(18, 9, "t5b_sync");
        check_eq("t5b_hs_before", int'(o_hd_hsync), 1);
        check_eq("t5b_vs_before", int'(o_hd_vsync), 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t5b_x", int'(o_hd_x), 0);
        check_eq("t5b_y", int'(o_hd_y), 0);
        check_eq("t5b_hs", int'(o_hd_hsync), 0);
        check_eq("t5b_vs", int'(o_hd_vsync), 0);
        check_eq("t5b_de", int'(o_hd_de), 0);
        check_eq("t5b_pix_en", int'(o_hd_pix_en), 0);
        check_eq("t5b_locked", int'(o_locked), 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("t5b_pix_en_after", int'(o_hd_pix_en), 1);
        check_eq("t5b_frame_start_after", int'(o_frame_start), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
